song_select_ctrl: RTL and testbench



---
 rtl/music_pkg.sv | 40 ++++
 rtl/song_end_detect.sv | 44 ++++
 rtl/song_select_ctrl.sv | 98 +++++++++
 tb/tb_song_select_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared constants, FSM encoding and song table lookup for the playlist
// controller and the song-length counter it drives.
package music_pkg;

  localparam int ADDR_W    = 10;
  localparam int NUM_SONGS = 3;

  localparam logic [ADDR_W-1:0] SONG1_START = 10'd0;
  localparam logic [ADDR_W-1:0] SONG1_END   = 10'd138;
  localparam logic [ADDR_W-1:0] SONG2_START = 10'd139;
  localparam logic [ADDR_W-1:0] SONG2_END   = 10'd335;
  localparam logic [ADDR_W-1:0] SONG3_START = 10'd336;
  localparam logic [ADDR_W-1:0] SONG3_END   = 10'd511;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] start_a;
    logic [ADDR_W-1:0] end_a;
  } song_range_t;

  // Index 0 and indices without a table entry map to an empty 0..0 range.
  function automatic song_range_t song_range(input logic [3:0] idx);
    song_range_t r;
    r.start_a = '0;
    r.end_a   = '0;
    case (idx)
      4'd1: begin r.start_a = SONG1_START; r.end_a = SONG1_END; end
      4'd2: begin r.start_a = SONG2_START; r.end_a = SONG2_END; end
      4'd3: begin r.start_a = SONG3_START; r.end_a = SONG3_END; end
      default: begin r.start_a = '0; r.end_a = '0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/song_end_detect.sv
// End-of-song detector: settle counter masking stale CNT8 after a reload,
// previous-match flag, and the registered one-cycle SONG_DONE pulse.
module song_end_detect
  import music_pkg::*;
#(
  parameter int ADDR_W = music_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic              suppress,
  input  logic [ADDR_W-1:0] cnt,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              end_hit,
  output logic              done
);

  logic [1:0] settle_q;
  logic       prev_q;
  logic       match;

  always_comb begin
    match   = enable && (settle_q == 2'd0) && (cnt == end_addr);
    // A simultaneous NEXT/PREV key takes precedence over the end event.
    end_hit = match && !prev_q && !suppress;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q <= 2'd0;
      prev_q   <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (load)
        settle_q <= 2'd2;
      else if (settle_q != 2'd0)
        settle_q <= settle_q - 2'd1;
      prev_q <= match;
      done   <= end_hit;
    end
  end

endmodule

// File: rtl/song_select_ctrl.sv
// Playlist controller: STOP/PLAY/PAUSE FSM, song index register and the
// registered STATE/address/RUN outputs feeding the song-length counter.
module song_select_ctrl
  import music_pkg::*;
#(
  parameter int NUM_SONGS = music_pkg::NUM_SONGS,
  parameter int ADDR_W    = music_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              KEY_PLAY,
  input  logic              KEY_NEXT,
  input  logic              KEY_PREV,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] CNT8,
  output logic [3:0]        STATE,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              RUN,
  output logic              SONG_DONE,
  output logic [1:0]        dbg_state
);

  // Keys are single-cycle debounced pulses; each is acted on in the cycle it
  // is high, with no acknowledge back to the debouncer.
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  idx_inc, idx_dec;
  logic        key_move;
  logic        settle_load;
  logic        end_hit;
  song_range_t rng;

  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    key_move    = KEY_NEXT ^ KEY_PREV;
    idx_inc     = (idx_q == 4'(NUM_SONGS)) ? 4'd1 : idx_q + 4'd1;
    idx_dec     = (idx_q == 4'd1) ? 4'(NUM_SONGS) : idx_q - 4'd1;

    case (state_q)
      ST_STOP:  if (KEY_PLAY) state_d = ST_PLAY;
      ST_PLAY:  if (KEY_PLAY) state_d = ST_PAUSE;
      ST_PAUSE: if (KEY_PLAY) state_d = ST_PLAY;
      default:  state_d = ST_STOP;
    endcase

    if (key_move)
      idx_d = KEY_NEXT ? idx_inc : idx_dec;
    else if (end_hit && !MODE)
      idx_d = idx_inc;

    settle_load = key_move || (end_hit && !MODE) ||
                  ((state_q == ST_STOP) && KEY_PLAY);
    rng = song_range(idx_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_STOP;
      idx_q      <= 4'd1;
      STATE      <= 4'd0;
      start_addr <= '0;
      end_addr   <= '0;
      RUN        <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Outside STOP the index only moves on a change event, so reloading
      // every cycle is the same as holding.
      if (state_d == ST_STOP) begin
        STATE      <= 4'd0;
        start_addr <= '0;
        end_addr   <= '0;
      end else begin
        STATE      <= idx_d;
        start_addr <= rng.start_a;
        end_addr   <= rng.end_a;
      end
      RUN <= (state_d == ST_PLAY);
    end
  end

  song_end_detect #(.ADDR_W(ADDR_W)) u_end_detect (
    .clk      (CLK),
    .rst      (RST),
    .enable   (state_q == ST_PLAY),
    .load     (settle_load),
    .suppress (key_move),
    .cnt      (CNT8),
    .end_addr (end_addr),
    .end_hit  (end_hit),
    .done     (SONG_DONE)
  );

endmodule

// File: tb/tb_song_select_ctrl.sv
// Directed bench for song_select_ctrl with an expected-output queue.
module tb_song_select_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       KEY_PLAY, KEY_NEXT, KEY_PREV, MODE;
  logic [9:0] CNT8;
  logic [3:0] STATE;
  logic [9:0] start_addr, end_addr;
  logic       RUN, SONG_DONE;
  logic [1:0] dbg_state;

  logic [27:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] F_STOP = 2'd0, F_PLAY = 2'd1, F_PAUSE = 2'd2;

  song_select_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_PLAY   (KEY_PLAY),
    .KEY_NEXT   (KEY_NEXT),
    .KEY_PREV   (KEY_PREV),
    .MODE       (MODE),
    .CNT8       (CNT8),
    .STATE      (STATE),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .RUN        (RUN),
    .SONG_DONE  (SONG_DONE),
    .dbg_state  (dbg_state)
  );

  always #5 CLK = ~CLK;

  // Expected word: {fsm, STATE, start_addr, end_addr, RUN, SONG_DONE}
  function automatic logic [27:0] ew(input logic [1:0] f, input int s,
                                     input logic run, input logic done);
    logic [9:0] sa, ea;
    case (s)
      1: begin sa = 10'd0;   ea = 10'd138; end
      2: begin sa = 10'd139; ea = 10'd335; end
      3: begin sa = 10'd336; ea = 10'd511; end
      default: begin sa = 10'd0; ea = 10'd0; end
    endcase
    return {f, 4'(s), sa, ea, run, done};
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic p,
                     input logic n, input logic v, input logic m,
                     input logic [9:0] c, input logic [27:0] exp);
    logic [27:0] obs, e;
    RST = rst; KEY_PLAY = p; KEY_NEXT = n; KEY_PREV = v; MODE = m; CNT8 = c;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    obs = {dbg_state, STATE, start_addr, end_addr, RUN, SONG_DONE};
    e = exp_q.pop_front();
    total_cnt++;
    assert (obs === e) pass_cnt++;
    else $error("FAIL %s: observed fsm=%0d state=%0d start=%0d end=%0d run=%0b done=%0b expected fsm=%0d state=%0d start=%0d end=%0d run=%0b done=%0b",
                tag, obs[27:26], obs[25:22], obs[21:12], obs[11:2], obs[1], obs[0],
                e[27:26], e[25:22], e[21:12], e[11:2], e[1], e[0]);
  endtask

  initial begin
    RST = 1'b1; KEY_PLAY = 0; KEY_NEXT = 0; KEY_PREV = 0; MODE = 0; CNT8 = '0;
    cyc("reset",        1, 0, 0, 0, 0, 10'd0,   ew(F_STOP, 0, 0, 0));
    cyc("idle_stop",    0, 0, 0, 0, 0, 10'd0,   ew(F_STOP, 0, 0, 0));
    cyc("stop_next",    0, 0, 1, 0, 0, 10'd0,   ew(F_STOP, 0, 0, 0));
    cyc("stop_prev",    0, 0, 0, 1, 0, 10'd0,   ew(F_STOP, 0, 0, 0));
    cyc("play_start",   0, 1, 0, 0, 0, 10'd0,   ew(F_PLAY, 1, 1, 0));
    // end match masked for two cycles after the load
    cyc("settle_a",     0, 0, 0, 0, 0, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("settle_b",     0, 0, 0, 0, 0, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("seq_end",      0, 0, 0, 0, 0, 10'd138, ew(F_PLAY, 2, 1, 1));
    cyc("seq_hold",     0, 0, 0, 0, 0, 10'd138, ew(F_PLAY, 2, 1, 0));
    cyc("seq_idle",     0, 0, 0, 0, 0, 10'd0,   ew(F_PLAY, 2, 1, 0));
    cyc("prev_to_1",    0, 0, 0, 1, 0, 10'd0,   ew(F_PLAY, 1, 1, 0));
    cyc("rep_settle_a", 0, 0, 0, 0, 1, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("rep_settle_b", 0, 0, 0, 0, 1, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("rep_end",      0, 0, 0, 0, 1, 10'd138, ew(F_PLAY, 1, 1, 1));
    cyc("rep_hold",     0, 0, 0, 0, 1, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("rep_hold2",    0, 0, 0, 0, 1, 10'd138, ew(F_PLAY, 1, 1, 0));
    cyc("rep_idle",     0, 0, 0, 0, 1, 10'd0,   ew(F_PLAY, 1, 1, 0));
    cyc("next_2",       0, 0, 1, 0, 0, 10'd0,   ew(F_PLAY, 2, 1, 0));
    cyc("next_3",       0, 0, 1, 0, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    cyc("next_wrap",    0, 0, 1, 0, 0, 10'd0,   ew(F_PLAY, 1, 1, 0));
    cyc("prev_wrap",    0, 0, 0, 1, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    cyc("next_prev",    0, 0, 1, 1, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    // reload to song 2 while CNT8 still sits at its end address
    cyc("mask_load",    0, 0, 0, 1, 0, 10'd335, ew(F_PLAY, 2, 1, 0));
    cyc("mask_c1",      0, 0, 0, 0, 0, 10'd335, ew(F_PLAY, 2, 1, 0));
    cyc("mask_c2",      0, 0, 0, 0, 0, 10'd335, ew(F_PLAY, 2, 1, 0));
    cyc("mask_done",    0, 0, 0, 0, 0, 10'd335, ew(F_PLAY, 3, 1, 1));
    cyc("mask_after",   0, 0, 0, 0, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    cyc("idle_s3",      0, 0, 0, 0, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    cyc("key_vs_end",   0, 0, 1, 0, 0, 10'd511, ew(F_PLAY, 1, 1, 0));
    cyc("key_vs_end2",  0, 0, 0, 0, 0, 10'd511, ew(F_PLAY, 1, 1, 0));
    cyc("pause",        0, 1, 0, 0, 0, 10'd0,   ew(F_PAUSE, 1, 0, 0));
    cyc("pause_noend",  0, 0, 0, 0, 0, 10'd138, ew(F_PAUSE, 1, 0, 0));
    cyc("pause_noend2", 0, 0, 0, 0, 0, 10'd138, ew(F_PAUSE, 1, 0, 0));
    cyc("pause_next",   0, 0, 1, 0, 0, 10'd0,   ew(F_PAUSE, 2, 0, 0));
    cyc("resume",       0, 1, 0, 0, 0, 10'd0,   ew(F_PLAY, 2, 1, 0));
    cyc("play_next",    0, 1, 1, 0, 0, 10'd0,   ew(F_PAUSE, 3, 0, 0));
    cyc("resume2",      0, 1, 0, 0, 0, 10'd0,   ew(F_PLAY, 3, 1, 0));
    cyc("rst_mid",      1, 0, 0, 0, 0, 10'd511, ew(F_STOP, 0, 0, 0));
    cyc("post_rst",     0, 0, 0, 0, 0, 10'd511, ew(F_STOP, 0, 0, 0));
    cyc("replay",       0, 1, 0, 0, 0, 10'd0,   ew(F_PLAY, 1, 1, 0));
    cyc("stop_next_play_a", 0, 0, 0, 0, 0, 10'd0, ew(F_PLAY, 1, 1, 0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
